// File: rtl/b1_demux_1_3_rr_dist.sv
// b1_demux_1_3_rr_dist
//   Sequential front end for a 1-to-3 bit demultiplexer stage. Accepts 1-bit
//   items over a valid/ready handshake and distributes them round-robin over
//   three channels, skipping channels disabled in en_mask. Each channel owns a
//   one-entry registered slot with its own valid/ready. The current select
//   code is exported so a combinational 1-to-3 demux can follow in lock-step.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   din, din_vld        input item and its valid
//   din_rdy             item accepted this cycle when din_vld & din_rdy
//   en_mask[2:0]        per-channel enable, sampled every cycle
//   sel[1:0]            channel receiving the next accepted item (0..2)
//   dout0..2, vld0..2   registered channel slots
//   rdy0..2             downstream pop (pop = vldi & rdyi)
//   drop_cnt[CNT_W-1:0] saturating count of items discarded with en_mask == 0
module b1_demux_1_3_rr_dist #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [2:0]       en_mask,
  output logic [1:0]       sel,
  output logic             dout0,
  output logic             dout1,
  output logic             dout2,
  output logic             vld0,
  output logic             vld1,
  output logic             vld2,
  input  logic             rdy0,
  input  logic             rdy1,
  input  logic             rdy2,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    PTR_CH0 = 2'd0,
    PTR_CH1 = 2'd1,
    PTR_CH2 = 2'd2
  } ptr_e;

  ptr_e             r_ptr;
  ptr_e             w_ptr_nxt;
  logic [1:0]       w_sel;
  logic [2:0]       r_vld;
  logic [2:0]       r_dout;
  logic [2:0]       w_rdy;
  logic [2:0]       w_pop;
  logic [2:0]       w_fill;
  logic             w_any_en;
  logic             w_xfer;
  logic             w_load;
  logic             w_drop;
  logic [CNT_W-1:0] r_drop_cnt;

  assign w_rdy    = {rdy2, rdy1, rdy0};
  assign w_any_en = |en_mask;

  // First enabled channel at or after the pointer; falls back to the pointer
  // itself when every channel is disabled (drop mode).
  always_comb begin
    w_sel = r_ptr;
    case (r_ptr)
      PTR_CH0: begin
        if      (en_mask[0]) w_sel = 2'd0;
        else if (en_mask[1]) w_sel = 2'd1;
        else if (en_mask[2]) w_sel = 2'd2;
      end
      PTR_CH1: begin
        if      (en_mask[1]) w_sel = 2'd1;
        else if (en_mask[2]) w_sel = 2'd2;
        else if (en_mask[0]) w_sel = 2'd0;
      end
      PTR_CH2: begin
        if      (en_mask[2]) w_sel = 2'd2;
        else if (en_mask[0]) w_sel = 2'd0;
        else if (en_mask[1]) w_sel = 2'd1;
      end
      default: w_sel = 2'd0;
    endcase
  end

  // A full slot that is popped this cycle may be refilled in the same cycle.
  always_comb begin
    din_rdy = 1'b0;
    if (!rst) din_rdy = w_any_en ? (!r_vld[w_sel] | w_rdy[w_sel]) : 1'b1;
  end

  assign w_xfer = din_vld & din_rdy;
  assign w_load = w_xfer & w_any_en;
  assign w_drop = w_xfer & ~w_any_en;
  assign w_fill = w_load ? (3'b001 << w_sel) : '0;
  assign w_pop  = r_vld & w_rdy;

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_load) begin
      case (w_sel)
        2'd0:    w_ptr_nxt = PTR_CH1;
        2'd1:    w_ptr_nxt = PTR_CH2;
        default: w_ptr_nxt = PTR_CH0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= PTR_CH0;
    else     r_ptr <= w_ptr_nxt;
  end

  // Refill takes priority over pop so a simultaneous pop+refill keeps vld high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_dout <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_fill[i]) begin
          r_vld[i]  <= 1'b1;
          r_dout[i] <= din;
        end else if (w_pop[i]) begin
          r_vld[i]  <= 1'b0;
          r_dout[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1))  r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign sel      = w_sel;
  assign dout0    = r_dout[0];
  assign dout1    = r_dout[1];
  assign dout2    = r_dout[2];
  assign vld0     = r_vld[0];
  assign vld1     = r_vld[1];
  assign vld2     = r_vld[2];
  assign drop_cnt = r_drop_cnt;

endmodule
